// File: rtl/long_prim_pipe.sv
// long_prim_pipe
//   Pipelined XOR/NOT (or XOR/NOR) primitive chain. IO_PAIRS independent
//   (even, odd) bit lanes pass through DEPTH primitive levels, with a register
//   slice after every REG_EVERY levels (NSTG = DEPTH/REG_EVERY slices).
//   Each word carries its own mode bit. Valid/ready handshake on both sides.
//   Bubbles collapse.
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    input word, lane j = {in_data[2j+1] odd, in_data[2j] even}
//   in_mode    0: e'=~e, o'=e^o   1: e'=~(e|o), o'=e^o
//   in_valid   upstream word present
//   in_ready   pipe accepts this cycle
//   out_data   word after DEPTH levels (last slice register)
//   out_valid  out_data valid (last slice register)
//   out_ready  downstream accepts
//   out_count  delivered-word count, wraps
module long_prim_pipe #(
    parameter int unsigned IO_PAIRS  = 2,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned REG_EVERY = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*IO_PAIRS-1:0] in_data,
    input  logic                  in_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [2*IO_PAIRS-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      out_count
);

    localparam int unsigned W    = 2 * IO_PAIRS;
    localparam int unsigned NSTG = DEPTH / REG_EVERY;

    logic [W-1:0]    r_data [NSTG];
    logic [NSTG-1:0] r_mode;
    logic [NSTG-1:0] r_valid;
    logic [CNT_W-1:0] r_count;

    logic [NSTG:0]   w_adv;
    logic [W-1:0]    w_src_data [NSTG];
    logic [NSTG-1:0] w_src_mode;
    logic [NSTG-1:0] w_src_valid;
    logic [W-1:0]    w_next [NSTG];

    // REG_EVERY primitive levels applied to every lane of a word.
    function automatic logic [W-1:0] f_levels(input logic [W-1:0] d, input logic m);
        logic [W-1:0] x;
        logic         e;
        logic         o;
        x = d;
        for (int unsigned l = 0; l < REG_EVERY; l++) begin
            for (int unsigned j = 0; j < IO_PAIRS; j++) begin
                e          = x[2*j];
                o          = x[2*j+1];
                x[2*j]     = m ? ~(e | o) : ~e;
                x[2*j+1]   = e ^ o;
            end
        end
        return x;
    endfunction

    // Advance chain runs from the output back to the input: a slice may load
    // if it is empty or if the slice after it is loading too.
    always_comb begin
        w_adv       = '0;
        w_adv[NSTG] = out_ready;
        for (int unsigned k = NSTG; k > 0; k--) begin
            w_adv[k-1] = ~r_valid[k-1] | w_adv[k];
        end
    end

    always_comb begin
        w_src_valid = '0;
        w_src_mode  = '0;
        for (int unsigned k = 0; k < NSTG; k++) begin
            w_src_data[k] = '0;
            w_next[k]     = '0;
        end
        w_src_valid[0] = in_valid;
        w_src_mode[0]  = in_mode;
        w_src_data[0]  = in_data;
        for (int unsigned k = 1; k < NSTG; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_mode[k]  = r_mode[k-1];
            w_src_data[k]  = r_data[k-1];
        end
        for (int unsigned k = 0; k < NSTG; k++) begin
            w_next[k] = f_levels(w_src_data[k], w_src_mode[k]);
        end
    end

    // Data/mode only load alongside a valid word, so bubbles never carry
    // stray input data into a slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_mode  <= '0;
            for (int unsigned k = 0; k < NSTG; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    if (w_src_valid[k]) begin
                        r_data[k] <= w_next[k];
                        r_mode[k] <= w_src_mode[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_valid[NSTG-1] && out_ready) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_valid[NSTG-1];
    assign out_data  = r_data[NSTG-1];
    assign out_count = r_count;

endmodule

// File: tb/tb_long_prim_pipe.sv
// tb_long_prim_pipe
//   Directed bench for long_prim_pipe. Main instance (defaults) is checked
//   every cycle against a queue model of in-flight words; two extra instances
//   cover DEPTH=6/REG_EVERY=2 and CNT_W=4 with literal expectations.
module tb_long_prim_pipe;

    localparam int unsigned DEPTH_M = 32;
    localparam int unsigned NSTG_M  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic [3:0]  m_in_data = '0;
    logic        m_in_mode = 1'b0;
    logic        m_in_valid = 1'b0;
    logic        m_in_ready;
    logic [3:0]  m_out_data;
    logic        m_out_valid;
    logic        m_out_ready = 1'b0;
    logic [15:0] m_out_count;

    // short instance: DEPTH=6, REG_EVERY=2
    logic [3:0]  s_in_data = '0;
    logic        s_in_mode = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [3:0]  s_out_data;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [15:0] s_out_count;

    // narrow counter instance: CNT_W=4
    logic [3:0]  c_in_data = '0;
    logic        c_in_mode = 1'b0;
    logic        c_in_valid = 1'b0;
    logic        c_in_ready;
    logic [3:0]  c_out_data;
    logic        c_out_valid;
    logic        c_out_ready = 1'b0;
    logic [3:0]  c_out_count;

    long_prim_pipe u_main (
        .clk(clk), .rst_n(rst_n),
        .in_data(m_in_data), .in_mode(m_in_mode), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(m_out_ready), .out_count(m_out_count)
    );

    long_prim_pipe #(.DEPTH(6), .REG_EVERY(2)) u_short (
        .clk(clk), .rst_n(rst_n),
        .in_data(s_in_data), .in_mode(s_in_mode), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_count(s_out_count)
    );

    long_prim_pipe #(.CNT_W(4)) u_cnt (
        .clk(clk), .rst_n(rst_n),
        .in_data(c_in_data), .in_mode(c_in_mode), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_count(c_out_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Closed-form result of DEPTH_M levels: mode 0 repeats every 4 levels,
    // mode 1 settles at (e=0, o=1) after at most 3 levels.
    function automatic logic [3:0] exp_word(input logic [3:0] d, input logic m);
        logic [3:0] r;
        logic e;
        logic o;
        r = '0;
        for (int j = 0; j < 2; j++) begin
            e = d[2*j];
            o = d[2*j+1];
            if (m) begin
                r[2*j] = 1'b0; r[2*j+1] = 1'b1;
            end else begin
                case (DEPTH_M % 4)
                    0: begin r[2*j] = e;  r[2*j+1] = o;        end
                    1: begin r[2*j] = ~e; r[2*j+1] = e ^ o;    end
                    2: begin r[2*j] = e;  r[2*j+1] = ~o;       end
                    default: begin r[2*j] = ~e; r[2*j+1] = ~(e ^ o); end
                endcase
            end
        end
        return r;
    endfunction

    // Model of the main instance: words in flight, in order.
    logic [3:0]  q [$];
    logic [15:0] mcount = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mcount = '0;
        end else begin
            chk("cmp_in_ready", m_in_ready, (q.size() < NSTG_M) || m_out_ready);
            chk("cmp_count", m_out_count, mcount);
            if (m_out_valid) begin
                chk("cmp_word_in_flight", q.size() != 0, 1);
                if (q.size() != 0) begin
                    chk("cmp_data", m_out_data, q[0]);
                    if (m_out_ready) begin
                        void'(q.pop_front());
                        mcount++;
                    end
                end
            end
            if (m_in_valid && m_in_ready) q.push_back(exp_word(m_in_data, m_in_mode));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [3:0] words [8];
    int sent;
    int drop_seen;
    logic acc;
    int guard;

    initial begin
        words[0] = 4'h3; words[1] = 4'h5; words[2] = 4'h6; words[3] = 4'h9;
        words[4] = 4'hC; words[5] = 4'h1; words[6] = 4'hE; words[7] = 4'h7;

        // reset state
        #12;
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_out_data",  m_out_data, 0);
        chk("rst_out_count", m_out_count, 0);
        chk("rst_in_ready",  m_in_ready, 1);
        rst_n = 1'b1;
        tick();

        // pin the model itself
        chk("model_m0", exp_word(4'b1011, 1'b0), 4'b1011);
        chk("model_m1", exp_word(4'b0001, 1'b1), 4'b1010);

        // mode 0, identity after 32 levels, latency 4
        m_out_ready = 1'b1;
        m_in_data = 4'b1011; m_in_mode = 1'b0; m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0; m_in_data = 4'b1111;
        tick(); tick();
        chk("t1_not_yet", m_out_valid, 0);
        tick();
        chk("t1_valid", m_out_valid, 1);
        chk("t1_data", m_out_data, 4'b1011);
        tick();
        chk("t1_count", m_out_count, 1);
        chk("t1_drained", m_out_valid, 0);

        // mode 1 converges
        m_in_data = 4'b0001; m_in_mode = 1'b1; m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        tick(); tick(); tick();
        chk("t2_valid", m_out_valid, 1);
        chk("t2_data", m_out_data, 4'b1010);
        tick();
        chk("t2_count", m_out_count, 2);

        // 8-word stream with a 6-cycle downstream stall
        sent = 0; drop_seen = 0;
        for (int cyc = 0; cyc < 60 && sent < 8; cyc++) begin
            m_out_ready = !(cyc >= 3 && cyc < 9);
            m_in_valid  = 1'b1;
            m_in_data   = words[sent];
            m_in_mode   = sent[0];
            #1;
            acc = m_in_ready;
            if (!acc && drop_seen == 0) begin
                drop_seen = 1;
                chk("t4_drop_after", sent, 4);
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        m_in_valid = 1'b0; m_out_ready = 1'b1;
        chk("t4_all_sent", sent, 8);
        chk("t4_ready_dropped", drop_seen, 1);
        guard = 0;
        while (m_out_count != 16'd10 && guard < 20) begin tick(); guard++; end
        chk("t4_count", m_out_count, 10);

        // DEPTH=6, REG_EVERY=2: 3 slices
        s_out_ready = 1'b1;
        s_in_valid = 1'b1; s_in_data = 4'b0000; s_in_mode = 1'b0;
        tick();
        s_in_data = 4'b0101; s_in_mode = 1'b0;
        tick();
        chk("t3_not_yet", s_out_valid, 0);
        s_in_data = 4'b0011; s_in_mode = 1'b1;
        tick();
        s_in_valid = 1'b0;
        chk("t3_valid", s_out_valid, 1);
        chk("t3_w0", s_out_data, 4'b1010);
        tick();
        chk("t3_w1", s_out_data, 4'b1111);
        tick();
        chk("t3_w2", s_out_data, 4'b1010);
        tick();
        chk("t3_drained", s_out_valid, 0);
        chk("t3_count", s_out_count, 3);

        // CNT_W=4 wrap after 17 transfers
        c_out_ready = 1'b1;
        c_in_valid = 1'b1; c_in_data = 4'h6; c_in_mode = 1'b0;
        repeat (17) tick();
        c_in_valid = 1'b0;
        chk("t5_count_mid", c_out_count, 13);
        repeat (4) tick();
        chk("t5_count_wrap", c_out_count, 1);
        chk("t5_drained", c_out_valid, 0);

        // async reset with 3 words in flight
        m_out_ready = 1'b1;
        m_in_valid = 1'b1;
        m_in_data = 4'h3; m_in_mode = 1'b0; tick();
        m_in_data = 4'h5; m_in_mode = 1'b1; tick();
        m_in_data = 4'h6; m_in_mode = 1'b0; tick();
        m_in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_valid_now", m_out_valid, 0);
        chk("t6_count_now", m_out_count, 0);
        chk("t6_data_now", m_out_data, 0);
        #1 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("t6_no_stale", m_out_valid, 0);
            tick();
        end
        m_in_data = 4'b0110; m_in_mode = 1'b0; m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        tick(); tick(); tick();
        chk("t6_post_valid", m_out_valid, 1);
        chk("t6_post_data", m_out_data, 4'b0110);
        tick();
        chk("t6_post_count", m_out_count, 1);

        tick();
        chk("end_model_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
